// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and command bundle for the counter run/pause/clear sequencer.
// Pure type definitions: no latency, no backpressure.
package counter_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLR   = 2'd3
    } state_t;

    typedef struct packed {
        logic clear;
        logic stop;
        logic start;
        logic step;
        logic mode;
    } cmd_t;

endpackage

// File: rtl/counter_ctrl_tick.sv
// Prescaler: tick every TICK_DIV cycles while run is high, counter held at zero otherwise.
// Latency: tick is combinational from the counter; no backpressure (free-running while run).
module tick_gen #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = run && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear sequencer driving the lab counter's enable, mode select and clear.
// Latency: command registered at edge k, state/outputs update at edge k+1; no backpressure, overlapping commands resolve by priority.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DIV_W      = 26,
    parameter int CLR_CYCLES = 2
) (
    input  logic               clk_ctrl,
    input  logic               reset_n_ctrl,
    input  logic               start_ctrl,
    input  logic               stop_ctrl,
    input  logic               clear_ctrl,
    input  logic               step_ctrl,
    input  logic               mode_ctrl,
    output logic               enable_count,
    output logic               selector_count,
    output logic               reset_count,
    output logic [STATE_W-1:0] state_ctrl
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    cmd_t             cmd_d;
    cmd_t             cmd_q;
    state_t           state_q;
    state_t           state_nxt;
    logic [CLR_W-1:0] clr_cnt_q;
    logic [CLR_W-1:0] clr_cnt_nxt;
    logic             sel_load;
    logic             step_fire;
    logic             tick;

    assign cmd_d = '{clear: clear_ctrl, stop: stop_ctrl, start: start_ctrl,
                     step: step_ctrl, mode: mode_ctrl};

    always_ff @(posedge clk_ctrl or negedge reset_n_ctrl) begin
        if (!reset_n_ctrl) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    // Each branch acts on at most one command, giving clear > stop > start > step.
    always_comb begin
        state_nxt   = state_q;
        clr_cnt_nxt = clr_cnt_q;
        sel_load    = 1'b0;
        step_fire   = 1'b0;
        if (state_q != ST_CLR && cmd_q.clear) begin
            state_nxt   = ST_CLR;
            clr_cnt_nxt = CLR_LAST;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_q.start) begin
                        state_nxt = ST_RUN;
                        sel_load  = 1'b1;
                    end else if (cmd_q.step) begin
                        step_fire = 1'b1;
                        sel_load  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cmd_q.stop) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_q.stop) begin
                        state_nxt = ST_IDLE;
                    end else if (cmd_q.start) begin
                        state_nxt = ST_RUN;
                        sel_load  = 1'b1;
                    end else if (cmd_q.step) begin
                        step_fire = 1'b1;
                        sel_load  = 1'b1;
                    end
                end
                ST_CLR: begin
                    if (clr_cnt_q == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        clr_cnt_nxt = clr_cnt_q - CLR_W'(1);
                    end
                end
            endcase
        end
    end

    // Prescaler follows the next state so a stop suppresses a due tick and
    // the first tick lands TICK_DIV edges after the start is sampled.
    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clk     (clk_ctrl),
        .reset_n (reset_n_ctrl),
        .run     (state_nxt == ST_RUN),
        .tick    (tick)
    );

    always_ff @(posedge clk_ctrl or negedge reset_n_ctrl) begin
        if (!reset_n_ctrl) begin
            state_q        <= ST_CLR;
            clr_cnt_q      <= CLR_LAST;
            reset_count    <= 1'b1;
            enable_count   <= 1'b0;
            selector_count <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            clr_cnt_q    <= clr_cnt_nxt;
            reset_count  <= (state_nxt == ST_CLR);
            enable_count <= tick | step_fire;
            if (sel_load) begin
                selector_count <= cmd_q.mode;
            end
        end
    end

    assign state_ctrl = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench: TICK_DIV=4 instance for sequencing, TICK_DIV=1 instance for continuous-enable run.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic       clk_ctrl;
    logic       reset_n_ctrl;
    logic       start_ctrl;
    logic       stop_ctrl;
    logic       clear_ctrl;
    logic       step_ctrl;
    logic       mode_ctrl;
    logic       en0, sel0, rc0;
    logic [1:0] st0;
    logic       en1, sel1, rc1;
    logic [1:0] st1;

    int n_checks = 0;
    int n_fail   = 0;

    counter_ctrl #(.TICK_DIV(4), .DIV_W(3), .CLR_CYCLES(2)) dut0 (
        .clk_ctrl       (clk_ctrl),
        .reset_n_ctrl   (reset_n_ctrl),
        .start_ctrl     (start_ctrl),
        .stop_ctrl      (stop_ctrl),
        .clear_ctrl     (clear_ctrl),
        .step_ctrl      (step_ctrl),
        .mode_ctrl      (mode_ctrl),
        .enable_count   (en0),
        .selector_count (sel0),
        .reset_count    (rc0),
        .state_ctrl     (st0)
    );

    counter_ctrl #(.TICK_DIV(1), .DIV_W(1), .CLR_CYCLES(2)) dut1 (
        .clk_ctrl       (clk_ctrl),
        .reset_n_ctrl   (reset_n_ctrl),
        .start_ctrl     (start_ctrl),
        .stop_ctrl      (stop_ctrl),
        .clear_ctrl     (clear_ctrl),
        .step_ctrl      (step_ctrl),
        .mode_ctrl      (mode_ctrl),
        .enable_count   (en1),
        .selector_count (sel1),
        .reset_count    (rc1),
        .state_ctrl     (st1)
    );

    initial clk_ctrl = 1'b0;
    always #5 clk_ctrl = ~clk_ctrl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk_ctrl);
        #1;
    endtask

    // Drive a one-cycle command; returns just after the sampling edge.
    task automatic pulse(input logic st, input logic sp, input logic cl,
                         input logic sk, input logic md);
        start_ctrl = st;
        stop_ctrl  = sp;
        clear_ctrl = cl;
        step_ctrl  = sk;
        mode_ctrl  = md;
        edge1();
        start_ctrl = 1'b0;
        stop_ctrl  = 1'b0;
        clear_ctrl = 1'b0;
        step_ctrl  = 1'b0;
    endtask

    initial begin
        start_ctrl   = 1'b0;
        stop_ctrl    = 1'b0;
        clear_ctrl   = 1'b0;
        step_ctrl    = 1'b0;
        mode_ctrl    = 1'b0;
        reset_n_ctrl = 1'b1;
        #1 reset_n_ctrl = 1'b0;
        #1;
        check("rst_state", st0, ST_CLR);
        check("rst_reset_count", rc0, 1);
        check("rst_enable", en0, 0);
        check("rst_selector", sel0, 0);
        check("rst_state_div1", st1, ST_CLR);

        // Power-up clear runs two cycles after release.
        #10 reset_n_ctrl = 1'b1;
        edge1();
        check("pwrup_e1_state", st0, ST_CLR);
        check("pwrup_e1_reset_count", rc0, 1);
        edge1();
        check("pwrup_e2_state", st0, ST_IDLE);
        check("pwrup_e2_reset_count", rc0, 0);
        check("pwrup_e2_enable", en0, 0);
        check("pwrup_e2_state_div1", st1, ST_IDLE);
        edge1();
        edge1();

        // Start with decimal mode: pulses at +4, +8, +12 edges.
        pulse(1, 0, 0, 0, 1);
        check("start_latency_state", st0, ST_IDLE);
        for (int n = 1; n <= 12; n++) begin
            edge1();
            check($sformatf("run_enable_e%0d", n), en0, (n % 4 == 0) ? 1 : 0);
            if (n == 1) begin
                check("run_state", st0, ST_RUN);
                check("run_selector", sel0, 1);
            end
        end

        // Stop sampled on the edge whose tick would drive the next pulse.
        edge1();
        edge1();
        pulse(0, 1, 0, 0, 1);
        check("stop_sample_state", st0, ST_RUN);
        check("stop_sample_enable", en0, 0);
        edge1();
        check("pause_state", st0, ST_PAUSE);
        check("pause_suppressed_enable", en0, 0);
        for (int n = 0; n < 4; n++) begin
            edge1();
            check("pause_enable_quiet", en0, 0);
        end

        // Step in PAUSE: exactly one pulse, loads mode.
        pulse(0, 0, 0, 1, 0);
        check("step_sample_enable", en0, 0);
        edge1();
        check("step_enable", en0, 1);
        check("step_selector", sel0, 0);
        check("step_state", st0, ST_PAUSE);
        edge1();
        check("step_enable_single", en0, 0);

        // Resume restarts the prescaler period.
        pulse(1, 0, 0, 0, 1);
        for (int n = 1; n <= 4; n++) begin
            edge1();
            check($sformatf("resume_enable_e%0d", n), en0, (n == 4) ? 1 : 0);
            if (n == 1) begin
                check("resume_state", st0, ST_RUN);
                check("resume_selector", sel0, 1);
            end
        end

        // Clear beats stop and start.
        pulse(1, 1, 1, 0, 1);
        check("clr_sample_state", st0, ST_RUN);
        for (int n = 1; n <= 3; n++) begin
            edge1();
            check($sformatf("clr_state_e%0d", n), st0, (n < 3) ? ST_CLR : ST_IDLE);
            check($sformatf("clr_reset_count_e%0d", n), rc0, (n < 3) ? 1 : 0);
            check($sformatf("clr_enable_e%0d", n), en0, 0);
        end

        // Stop in IDLE is ignored; step in IDLE gives one pulse.
        pulse(0, 1, 0, 0, 1);
        edge1();
        check("idle_stop_state", st0, ST_IDLE);
        pulse(0, 0, 0, 1, 0);
        edge1();
        check("idle_step_enable", en0, 1);
        check("idle_step_selector", sel0, 0);
        check("idle_step_state", st0, ST_IDLE);
        edge1();

        // Async reset mid-RUN while a pulse is high.
        pulse(1, 0, 0, 0, 1);
        for (int n = 1; n <= 4; n++) edge1();
        check("pre_areset_enable", en0, 1);
        check("pre_areset_state", st0, ST_RUN);
        #2 reset_n_ctrl = 1'b0;
        #1;
        check("areset_state", st0, ST_CLR);
        check("areset_reset_count", rc0, 1);
        check("areset_enable", en0, 0);
        check("areset_selector", sel0, 0);

        // TICK_DIV=1: enable high every RUN cycle; mode changes ignored.
        #2 reset_n_ctrl = 1'b1;
        edge1();
        edge1();
        check("div1_idle_state", st1, ST_IDLE);
        pulse(1, 0, 0, 0, 1);
        check("div1_sample_enable", en1, 0);
        for (int n = 1; n <= 6; n++) begin
            if (n == 3) mode_ctrl = 1'b0;
            edge1();
            check($sformatf("div1_state_e%0d", n), st1, ST_RUN);
            check($sformatf("div1_enable_e%0d", n), en1, 1);
            check($sformatf("div1_selector_e%0d", n), sel1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
